// File: rtl/spi_mem_rd_fifo_pkg.sv
// Shared constants for the SPI slave-side byte FIFO: register map,
// CTRL/STATUS bit positions and the threshold reset value.
package spi_mem_rd_fifo_pkg;

    localparam logic [6:0] ADDR_CTRL    = 7'h00;
    localparam logic [6:0] ADDR_STATUS  = 7'h01;
    localparam logic [6:0] ADDR_LEVEL_L = 7'h02;
    localparam logic [6:0] ADDR_LEVEL_H = 7'h03;
    localparam logic [6:0] ADDR_THRESH  = 7'h04;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_UDF   = 3;

    localparam logic [7:0] THRESH_RST = 8'h80;

    // Packs the status flags into the STATUS register layout.
    function automatic logic [7:0] status_byte(input logic empty, input logic full,
                                               input logic ovf, input logic udf);
        return {4'b0000, udf, ovf, full, empty};
    endfunction

endpackage

// File: rtl/spi_mem_rd_fifo_ram.sv
// Simple dual-port byte RAM with synchronous write and registered read.
// The read register only updates on a read, so the last popped byte is held.
module spi_mem_rd_fifo_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_r [DEPTH];
    logic [7:0] rd_data_r;

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_r[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port register, cleared by reset and held between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_r <= 8'h00;
        end else if (rd_en_i) begin
            rd_data_r <= mem_r[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_r;

endmodule

// File: rtl/spi_mem_rd_fifo.sv
// Byte FIFO between the demodulator and the SPI slave, with a small
// control/status register bank and a level-threshold interrupt.
module spi_mem_rd_fifo
    import spi_mem_rd_fifo_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] din_i,
    input  logic       din_vld_i,
    input  logic       mem_rd_ena_i,
    output logic [7:0] mem_data_out_o,
    output logic       mem_ena_out_o,
    input  logic [6:0] reg_addr_i,
    input  logic [7:0] reg_data_i,
    input  logic       reg_rd_i,
    input  logic       reg_wr_i,
    output logic [7:0] reg_data_o,
    output logic       irq_o
);

    logic [AW:0]  wr_cnt_r, rd_cnt_r;
    logic         enable_r, irq_en_r, ovf_r, udf_r, ena_r, irq_r;
    logic [7:0]   thresh_r, reg_data_r;

    logic [AW:0]  level_s;
    logic [15:0]  level16_s, thresh16_s;
    logic         empty_s, full_s, flush_s, wr_ctrl_s, wr_status_s, wr_thresh_s;
    logic         push_ok_s, pop_ok_s, ovf_evt_s, udf_evt_s;
    logic [7:0]   rd_mux_s;

    // Occupancy, write decode and push/pop qualification from registered state.
    always_comb begin
        level_s     = wr_cnt_r - rd_cnt_r;
        level16_s   = 16'(level_s);
        thresh16_s  = {5'b00000, thresh_r, 3'b000};
        empty_s     = (level_s == '0);
        full_s      = (level16_s == 16'(DEPTH));
        wr_ctrl_s   = reg_wr_i && (reg_addr_i == ADDR_CTRL);
        wr_status_s = reg_wr_i && (reg_addr_i == ADDR_STATUS);
        wr_thresh_s = reg_wr_i && (reg_addr_i == ADDR_THRESH);
        flush_s     = wr_ctrl_s && reg_data_i[CTRL_FLUSH];
        push_ok_s   = 1'b0;
        ovf_evt_s   = 1'b0;
        pop_ok_s    = 1'b0;
        udf_evt_s   = 1'b0;
        if (flush_s) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            push_ok_s = din_vld_i && enable_r && !full_s;
            ovf_evt_s = din_vld_i && enable_r && full_s;
            pop_ok_s  = mem_rd_ena_i && !empty_s;
            udf_evt_s = mem_rd_ena_i && empty_s;
        end
    end

    // Register read multiplexer; unmapped addresses read zero.
    always_comb begin
        rd_mux_s = 8'h00;
        case (reg_addr_i)
            ADDR_CTRL:    rd_mux_s = {5'b00000, irq_en_r, 1'b0, enable_r};
            ADDR_STATUS:  rd_mux_s = status_byte(empty_s, full_s, ovf_r, udf_r);
            ADDR_LEVEL_L: rd_mux_s = level16_s[7:0];
            ADDR_LEVEL_H: rd_mux_s = level16_s[15:8];
            ADDR_THRESH:  rd_mux_s = thresh_r;
            default:      rd_mux_s = 8'h00;
        endcase
    end

    // Write/read counters; flush clears both and discards same-cycle traffic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
        end else if (flush_s) begin
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
        end else begin
            if (push_ok_s) wr_cnt_r <= wr_cnt_r + 1'b1;
            if (pop_ok_s)  rd_cnt_r <= rd_cnt_r + 1'b1;
        end
    end

    // Pop valid pulse, aligned with the RAM read register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ena_r <= 1'b0;
        else       ena_r <= pop_ok_s;
    end

    // CTRL and THRESH writable registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_r <= 1'b0;
            irq_en_r <= 1'b0;
            thresh_r <= THRESH_RST;
        end else begin
            if (wr_ctrl_s) begin
                enable_r <= reg_data_i[CTRL_ENABLE];
                irq_en_r <= reg_data_i[CTRL_IRQ_EN];
            end
            if (wr_thresh_s) thresh_r <= reg_data_i;
        end
    end

    // Sticky overflow/underflow flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_evt_s || (ovf_r && !(wr_status_s && reg_data_i[STAT_OVF]));
            udf_r <= udf_evt_s || (udf_r && !(wr_status_s && reg_data_i[STAT_UDF]));
        end
    end

    // Register read data, captured from pre-write state and held until the next read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         reg_data_r <= 8'h00;
        else if (reg_rd_i) reg_data_r <= rd_mux_s;
    end

    // Level-threshold interrupt, re-evaluated every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_r <= 1'b0;
        else       irq_r <= irq_en_r && (level16_s >= thresh16_s);
    end

    spi_mem_rd_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (push_ok_s),
        .wr_addr_i (wr_cnt_r[AW-1:0]),
        .wr_data_i (din_i),
        .rd_en_i   (pop_ok_s),
        .rd_addr_i (rd_cnt_r[AW-1:0]),
        .rd_data_o (mem_data_out_o)
    );

    assign mem_ena_out_o = ena_r;
    assign reg_data_o    = reg_data_r;
    assign irq_o         = irq_r;

endmodule
